// File: rtl/gpu_mem_cpu2vram_writer_if.sv
// FIFO-side and arbiter-side signals of the CPU->VRAM writer.
// The master modport is the writer; the slave modport is the FIFO/arbiter side.
interface gpu_mem_cpu2vram_writer_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic [31:0]    fifo_data_i;
    logic           fifo_valid_i;
    logic           fifo_pop_o;
    logic           wr_req_o;
    logic [X_W-1:0] wr_x_o;
    logic [Y_W-1:0] wr_y_o;
    logic [15:0]    wr_data_o;
    logic           wr_ack_i;

    modport master (
        input  fifo_data_i, fifo_valid_i, wr_ack_i,
        output fifo_pop_o, wr_req_o, wr_x_o, wr_y_o, wr_data_o
    );

    modport slave (
        output fifo_data_i, fifo_valid_i, wr_ack_i,
        input  fifo_pop_o, wr_req_o, wr_x_o, wr_y_o, wr_data_o
    );
endinterface

// File: rtl/gpu_mem_cpu2vram_writer.sv
// Pops 32-bit CPU words, splits them into two 16-bit pixels (low half first)
// and issues one VRAM write per pixel while walking the destination rectangle.
module gpu_mem_cpu2vram_writer #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [X_W-1:0]              pos_x_i,
    input  logic [Y_W-1:0]              pos_y_i,
    input  logic [X_W-1:0]              size_w_i,
    input  logic [Y_W-1:0]              size_h_i,
    input  logic                        set_mask_i,
    input  logic                        abort_i,
    gpu_mem_cpu2vram_writer_if.master   bus,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int CW = X_W + 1;
    localparam int RW = Y_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PIX_LO, S_PIX_HI, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [31:0]    r_word;
    logic [X_W-1:0] r_pos_x;
    logic [CW-1:0]  r_w;
    logic [RW-1:0]  r_h;
    logic           r_mask;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [X_W-1:0] r_cur_x;
    logic [Y_W-1:0] r_cur_y;

    logic           w_pix;
    logic           w_ack;
    logic           w_row_end;
    logic           w_last;
    logic [15:0]    w_half;

    assign w_pix     = (r_state == S_PIX_LO) || (r_state == S_PIX_HI);
    assign w_ack     = w_pix && bus.wr_ack_i && !abort_i;
    assign w_row_end = (r_col == r_w - CW'(1));
    assign w_last    = w_row_end && (r_row == r_h - RW'(1));
    assign w_half    = (r_state == S_PIX_HI) ? r_word[31:16] : r_word[15:0];

    assign bus.fifo_pop_o = (r_state == S_FETCH) && bus.fifo_valid_i && !abort_i;
    assign bus.wr_req_o   = w_pix && !abort_i;
    assign bus.wr_x_o     = r_cur_x;
    assign bus.wr_y_o     = r_cur_y;
    assign bus.wr_data_o  = w_pix ? {w_half[15] | r_mask, w_half[14:0]} : 16'd0;
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = (r_state == S_DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_state_next = S_FETCH;
            S_FETCH:  if (bus.fifo_valid_i) w_state_next = S_PIX_LO;
            // An odd pixel count ends in PIX_LO and drops the high half.
            S_PIX_LO: if (bus.wr_ack_i) w_state_next = w_last ? S_DONE : S_PIX_HI;
            S_PIX_HI: if (bus.wr_ack_i) w_state_next = w_last ? S_DONE : S_FETCH;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        // Start beats abort in IDLE because the override skips IDLE.
        if (r_state != S_IDLE && abort_i) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_pos_x <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_mask  <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && start_i) begin
                r_pos_x <= pos_x_i;
                r_w     <= (size_w_i == '0) ? CW'(1 << X_W) : CW'(size_w_i);
                r_h     <= (size_h_i == '0) ? RW'(1 << Y_W) : RW'(size_h_i);
                r_mask  <= set_mask_i;
                r_col   <= '0;
                r_row   <= '0;
                r_cur_x <= pos_x_i;
                r_cur_y <= pos_y_i;
            end
            if (bus.fifo_pop_o) begin
                r_word <= bus.fifo_data_i;
            end
            // Coordinates wrap naturally at the VRAM width/height.
            if (w_ack) begin
                if (w_row_end) begin
                    r_col   <= '0;
                    r_row   <= r_row + RW'(1);
                    r_cur_x <= r_pos_x;
                    r_cur_y <= r_cur_y + Y_W'(1);
                end else begin
                    r_col   <= r_col + CW'(1);
                    r_cur_x <= r_cur_x + X_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gpu_mem_cpu2vram_writer.sv
// Directed bench: a rectangle/word model predicts every pixel write and the
// pop count; a negedge checker compares each accepted write against it.
module tb_gpu_mem_cpu2vram_writer;
    logic       clk = 1'b0;
    logic       rst_i, start_i, set_mask_i, abort_i;
    logic [9:0] pos_x_i, size_w_i;
    logic [8:0] pos_y_i, size_h_i;
    logic       busy_o, done_o;

    always #5 clk = ~clk;

    gpu_mem_cpu2vram_writer_if bus ();

    gpu_mem_cpu2vram_writer dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .pos_x_i    (pos_x_i),
        .pos_y_i    (pos_y_i),
        .size_w_i   (size_w_i),
        .size_h_i   (size_h_i),
        .set_mask_i (set_mask_i),
        .abort_i    (abort_i),
        .bus        (bus),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    typedef struct {
        int x;
        int y;
        int d;
    } pix_t;

    pix_t        exp_q[$];
    pix_t        log_q[$];
    logic [31:0] fifo_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    int dones = 0;
    int stall_left = 0;
    int vhold = 0;
    int start_cyc = 0;
    int first_req_cyc = -1;
    int last_ack_cyc = -10;
    bit ack_en = 1'b1;
    bit pop_seen = 1'b0;
    bit pend = 1'b0;
    pix_t pend_p;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: pixel i of the rectangle is half (i%2) of word i/2, raster order, wrapped.
    task automatic build(input int px, input int py, input int w, input int h,
                         input bit mask, input logic [31:0] words[$]);
        logic [31:0] wd;
        int          half;
        for (int i = 0; i < w * h; i++) begin
            wd   = words[i / 2];
            half = (i % 2 == 1) ? int'(wd[31:16]) : int'(wd[15:0]);
            if (mask) half = half | 32'h8000;
            exp_q.push_back('{(px + i % w) % 1024, (py + i / w) % 512, half});
        end
    endtask

    // FIFO and arbiter model, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_seen         = 1'b0;
        bus.fifo_valid_i = (fifo_q.size() > 0) && (vhold == 0);
        bus.fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
        bus.wr_ack_i     = ack_en && (stall_left == 0);
    end

    // Compare process.
    always @(negedge clk) begin
        pix_t a;
        cyc++;
        if (rst_i) begin
            pend = 1'b0;
        end else begin
            if (start_i && !busy_o) start_cyc = cyc;
            if (busy_o && vhold > 0) vhold--;
            if (!bus.fifo_valid_i) chk("pop_without_valid", int'(bus.fifo_pop_o), 0);
            if (bus.fifo_pop_o) begin
                pops++;
                pop_seen = 1'b1;
            end
            a.x = int'(bus.wr_x_o);
            a.y = int'(bus.wr_y_o);
            a.d = int'(bus.wr_data_o);
            if (pend) begin
                chk("hold_req", int'(bus.wr_req_o), 1);
                chk("hold_x", a.x, pend_p.x);
                chk("hold_y", a.y, pend_p.y);
                chk("hold_data", a.d, pend_p.d);
            end
            pend = 1'b0;
            if (bus.wr_req_o) begin
                chk("req_needs_pop", int'(pops > 0), 1);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (bus.wr_ack_i) begin
                    chk("write_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        pix_t e;
                        e = exp_q.pop_front();
                        chk("wr_x", a.x, e.x);
                        chk("wr_y", a.y, e.y);
                        chk("wr_data", a.d, e.d);
                    end
                    log_q.push_back(a);
                    last_ack_cyc = cyc;
                end else begin
                    pend   = 1'b1;
                    pend_p = a;
                    if (stall_left > 0) stall_left--;
                end
            end
            if (done_o) begin
                dones++;
                chk("done_after_last_ack", cyc - last_ack_cyc, 1);
                chk("done_all_written", exp_q.size(), 0);
            end
        end
    end

    task automatic run(input string name, input int px, input int py, input int w,
                       input int h, input bit mask, input int stall, input int vh,
                       input bit chk_lat);
        logic [31:0] words[$];
        int          t;
        bit          seen;
        words = fifo_q;
        build(px, py, w, h, mask, words);
        pops = 0;
        dones = 0;
        log_q.delete();
        first_req_cyc = -1;
        stall_left = stall;
        vhold = vh;
        tick();
        pos_x_i    = 10'(px);
        pos_y_i    = 9'(py);
        size_w_i   = 10'(w);
        size_h_i   = 9'(h);
        set_mask_i = mask;
        start_i    = 1'b1;
        tick();
        start_i = 1'b0;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 5000) begin
            @(negedge clk);
            if (done_o) seen = 1'b1;
            t++;
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        chk({name, "_busy_after"}, int'(busy_o), 0);
        chk({name, "_done_one_cycle"}, int'(done_o), 0);
        chk({name, "_pops"}, pops, (w * h + 1) / 2);
        chk({name, "_writes"}, log_q.size(), w * h);
        chk({name, "_done_count"}, dones, 1);
        if (chk_lat) chk({name, "_latency"}, first_req_cyc - start_cyc, 2);
        $display("xfer %s pos=(%0d,%0d) size=%0dx%0d mask=%0d writes=%0d pops=%0d",
                 name, px, py, w, h, mask, log_q.size(), pops);
        exp_q.delete();
        fifo_q.delete();
    endtask

    // Cut a 2x2 transfer after its first accepted pixel with abort or reset.
    task automatic run_cut(input bit use_rst);
        logic [31:0] words[$];
        int          t;
        string       name;
        name = use_rst ? "reset_cut" : "abort_cut";
        fifo_q = '{32'h11112222, 32'h33334444};
        words = fifo_q;
        build(10, 20, 2, 2, 1'b0, words);
        pops = 0;
        dones = 0;
        log_q.delete();
        tick();
        pos_x_i  = 10'd10;
        pos_y_i  = 9'd20;
        size_w_i = 10'd2;
        size_h_i = 9'd2;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.wr_req_o && bus.wr_ack_i) && t < 100);
        chk({name, "_first_ack"}, int'(bus.wr_req_o && bus.wr_ack_i), 1);
        tick();
        if (use_rst) rst_i = 1'b1;
        else abort_i = 1'b1;
        @(negedge clk);
        if (!use_rst) begin
            chk({name, "_req_during"}, int'(bus.wr_req_o), 0);
            chk({name, "_pop_during"}, int'(bus.fifo_pop_o), 0);
        end
        tick();
        rst_i   = 1'b0;
        abort_i = 1'b0;
        @(negedge clk);
        chk({name, "_busy"}, int'(busy_o), 0);
        chk({name, "_req"}, int'(bus.wr_req_o), 0);
        if (use_rst) begin
            chk({name, "_wr_x"}, int'(bus.wr_x_o), 0);
            chk({name, "_wr_y"}, int'(bus.wr_y_o), 0);
            chk({name, "_wr_data"}, int'(bus.wr_data_o), 0);
        end
        exp_q.delete();
        repeat (6) @(negedge clk);
        chk({name, "_writes"}, log_q.size(), 1);
        chk({name, "_no_done"}, dones, 0);
        chk({name, "_pops"}, pops, 1);
        $display("xfer %s writes=%0d pops=%0d dones=%0d", name, log_q.size(), pops, dones);
        fifo_q.delete();
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        set_mask_i = 1'b0;
        pos_x_i = '0;
        pos_y_i = '0;
        size_w_i = '0;
        size_h_i = '0;
        bus.fifo_data_i = '0;
        bus.fifo_valid_i = 1'b0;
        bus.wr_ack_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_req", int'(bus.wr_req_o), 0);
        chk("reset_pop", int'(bus.fifo_pop_o), 0);
        chk("reset_wr_x", int'(bus.wr_x_o), 0);
        chk("reset_wr_y", int'(bus.wr_y_o), 0);
        chk("reset_wr_data", int'(bus.wr_data_o), 0);
        tick();
        rst_i = 1'b0;

        fifo_q = '{32'h11112222, 32'h33334444};
        run("2x2", 10, 20, 2, 2, 1'b0, 0, 0, 1'b1);
        if (log_q.size() == 4) begin
            chk("2x2_p0_x", log_q[0].x, 10);
            chk("2x2_p0_y", log_q[0].y, 20);
            chk("2x2_p0_d", log_q[0].d, 32'h2222);
            chk("2x2_p1_d", log_q[1].d, 32'h1111);
            chk("2x2_p3_x", log_q[3].x, 11);
            chk("2x2_p3_y", log_q[3].y, 21);
            chk("2x2_p3_d", log_q[3].d, 32'h3333);
        end

        fifo_q = '{32'hAAAABBBB, 32'hCCCCDDDD};
        run("odd3x1", 0, 0, 3, 1, 1'b0, 0, 0, 1'b1);
        if (log_q.size() == 3) begin
            chk("odd_p1_d", log_q[1].d, 32'hAAAA);
            chk("odd_p2_d", log_q[2].d, 32'hDDDD);
        end

        fifo_q = '{32'h00020001, 32'h00040003};
        run("wrap", 1023, 511, 2, 2, 1'b0, 0, 0, 1'b0);
        if (log_q.size() == 4) begin
            chk("wrap_p0_x", log_q[0].x, 1023);
            chk("wrap_p1_x", log_q[1].x, 0);
            chk("wrap_p1_y", log_q[1].y, 511);
            chk("wrap_p2_x", log_q[2].x, 1023);
            chk("wrap_p2_y", log_q[2].y, 0);
        end

        fifo_q = '{32'h12345678, 32'h9ABCDEF0};
        run("backpressure", 100, 200, 2, 2, 1'b0, 5, 0, 1'b0);

        fifo_q = '{32'h0BAD_F00D};
        run("fifo_empty", 50, 60, 2, 1, 1'b0, 0, 4, 1'b0);

        fifo_q = '{32'h00010002};
        run("mask", 0, 0, 2, 1, 1'b1, 0, 0, 1'b1);
        if (log_q.size() == 2) begin
            chk("mask_p0_d", log_q[0].d, 32'h8002);
            chk("mask_p1_d", log_q[1].d, 32'h8001);
        end

        for (int k = 0; k < 512; k++) fifo_q.push_back({16'(2 * k + 1), 16'(2 * k)});
        run("w1024", 5, 7, 1024, 1, 1'b0, 0, 0, 1'b1);
        if (log_q.size() == 1024) begin
            chk("w1024_last_x", log_q[1023].x, 4);
            chk("w1024_last_y", log_q[1023].y, 7);
            chk("w1024_last_d", log_q[1023].d, 32'h03FF);
        end

        run_cut(1'b0);
        run_cut(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
